// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, state encodings and mux select codes for the multicycle MIPS control
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:   return S_MEMADR;
      OP_RTYPE:       return S_EXECUTE;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_ADDI:        return S_ADDIEX;
      OP_J:           return S_JUMP;
      default:        return S_TRAP;
    endcase
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: watchdog counting memory wait cycles, flags expiry on the last allowed wait cycle
// ports: clk, resetN (async active-low), clear (restart count), waiting (in a memory state),
//        memReady (access done this cycle), expired (give up on the access this cycle)
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic waiting,
  input  logic memReady,
  output logic expired
);
  localparam int CW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [CW-1:0] cnt;
  // expiry is combinational so the FSM leaves on the cycle the count reaches the limit;
  // a ready in that same cycle masks it, letting the access complete
  assign expired = (TIMEOUT_CYCLES != 0) && waiting && !memReady && cnt == LIM;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (waiting && !memReady && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS datapath
// ports: clk, resetN (async active-low), opcode/zero/memReady in; memory handshake, datapath
//        mux selects and write enables out; illegalOp/busErr sticky trap causes; state for debug
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               memReady,
  output logic               memReq,
  output logic               memWrite,
  output logic               iOrD,
  output logic               irWrite,
  output logic               regWrite,
  output logic               regDst,
  output logic               memToReg,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         pcSrc,
  output logic               pcEn,
  output logic               illegalOp,
  output logic               busErr,
  output logic [STATE_W-1:0] state
);
  state_t st, nxt;
  logic [5:0] op_latched;
  logic waiting, expired;
  assign waiting = st inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  assign state = STATE_W'(st);
  // clearing on every state change restarts the count on entry to each memory state
  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (nxt != st),
    .waiting  (waiting),
    .memReady (memReady),
    .expired  (expired)
  );
  always_comb begin
    nxt = st;
    case (st)
      S_FETCH:    nxt = memReady ? S_DECODE : expired ? S_TRAP : S_FETCH;
      S_DECODE:   nxt = decode_next(opcode);
      S_MEMADR:   nxt = op_latched == OP_LW ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = memReady ? S_MEMWB : expired ? S_TRAP : S_MEMREAD;
      S_MEMWRITE: nxt = memReady ? S_FETCH : expired ? S_TRAP : S_MEMWRITE;
      S_EXECUTE:  nxt = S_ALUWB;
      S_ADDIEX:   nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: nxt = S_FETCH;
      default:    nxt = S_TRAP;
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      st <= S_FETCH;
      op_latched <= '0;
      illegalOp <= 1'b0;
      busErr <= 1'b0;
    end else begin
      st <= nxt;
      if (st == S_DECODE) op_latched <= opcode;
      if (st == S_DECODE && nxt == S_TRAP) illegalOp <= 1'b1;
      if (expired) busErr <= 1'b1;
    end
  // decode is gated by resetN so enables drop the instant reset asserts, not at the next edge
  always_comb begin
    memReq = 1'b0;
    memWrite = 1'b0;
    iOrD = 1'b0;
    irWrite = 1'b0;
    regWrite = 1'b0;
    regDst = 1'b0;
    memToReg = 1'b0;
    aluSrcA = 1'b0;
    aluSrcB = SRCB_B;
    aluOp = ALUOP_ADD;
    pcSrc = PC_ALU;
    pcEn = 1'b0;
    if (resetN)
      case (st)
        S_FETCH: begin
          memReq = 1'b1;
          aluSrcB = SRCB_FOUR;
          irWrite = memReady;
          pcEn = memReady;
        end
        S_DECODE: aluSrcB = SRCB_IMMSH;
        S_MEMADR: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
        end
        S_MEMREAD: begin
          memReq = 1'b1;
          iOrD = 1'b1;
        end
        S_MEMWB: begin
          regWrite = 1'b1;
          memToReg = 1'b1;
        end
        S_MEMWRITE: begin
          memReq = 1'b1;
          memWrite = 1'b1;
          iOrD = 1'b1;
        end
        S_EXECUTE: begin
          aluSrcA = 1'b1;
          aluOp = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          regWrite = 1'b1;
          regDst = 1'b1;
        end
        S_BRANCH: begin
          aluSrcA = 1'b1;
          aluOp = ALUOP_SUB;
          pcSrc = PC_ALUOUT;
          pcEn = op_latched == OP_BNE ? !zero : zero;
        end
        S_ADDIEX: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
        end
        S_ADDIWB: regWrite = 1'b1;
        S_JUMP: begin
          pcSrc = PC_JUMP;
          pcEn = 1'b1;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench driving directed instruction sequences through the control FSM
module tb_multicycle_control;
  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
  localparam logic [3:0] EX = 4'd6, AWB = 4'd7, BR = 4'd8, AIX = 4'd9, AIW = 4'd10, JP = 4'd11, TR = 4'd12;
  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  logic clk = 1'b0, resetN = 1'b0, zero = 1'b0, memReady = 1'b0;
  logic [5:0] opcode = '0;
  logic memReq, memWrite, iOrD, irWrite, regWrite, regDst, memToReg, aluSrcA, pcEn, illegalOp, busErr;
  logic [1:0] aluSrcB, aluOp, pcSrc;
  logic [3:0] state;
  int tests = 0, fails = 0;

  typedef struct {
    string nm;
    logic [20:0] v;
  } item_t;
  item_t sb[$];
  item_t it;

  multicycle_control #(.TIMEOUT_CYCLES(4), .STATE_W(4)) dut (
    .clk(clk), .resetN(resetN), .opcode(opcode), .zero(zero), .memReady(memReady),
    .memReq(memReq), .memWrite(memWrite), .iOrD(iOrD), .irWrite(irWrite), .regWrite(regWrite),
    .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSrc(pcSrc), .pcEn(pcEn), .illegalOp(illegalOp), .busErr(busErr), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] exp_vec(input logic [3:0] s, input logic mr, input logic z,
                                          input logic [5:0] op, input logic ill, input logic be);
    logic req = 0, wr = 0, iod = 0, irw = 0, rw = 0, rd = 0, m2r = 0, sa = 0, pe = 0;
    logic [1:0] sb_ = 0, ao = 0, ps = 0;
    case (s)
      F:   begin req = 1; sb_ = 2'b01; irw = mr; pe = mr; end
      D:   sb_ = 2'b11;
      MA:  begin sa = 1; sb_ = 2'b10; end
      MR:  begin req = 1; iod = 1; end
      MWB: begin rw = 1; m2r = 1; end
      MW:  begin req = 1; wr = 1; iod = 1; end
      EX:  begin sa = 1; ao = 2'b10; end
      AWB: begin rw = 1; rd = 1; end
      BR:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = (op == BNE) ? !z : z; end
      AIX: begin sa = 1; sb_ = 2'b10; end
      AIW: rw = 1;
      JP:  begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {s, req, wr, iod, irw, rw, rd, m2r, sa, sb_, ao, ps, pe, ill, be};
  endfunction

  always @(negedge clk)
    if (sb.size() != 0) begin
      it = sb.pop_front();
      tests++;
      if ({state, memReq, memWrite, iOrD, irWrite, regWrite, regDst, memToReg, aluSrcA,
           aluSrcB, aluOp, pcSrc, pcEn, illegalOp, busErr} !== it.v) begin
        fails++;
        $display("FAIL %s: got %h expected %h (state %0d)", it.nm,
                 {state, memReq, memWrite, iOrD, irWrite, regWrite, regDst, memToReg, aluSrcA,
                  aluSrcB, aluOp, pcSrc, pcEn, illegalOp, busErr}, it.v, state);
      end
    end

  task automatic cyc(input string nm, input logic mr, input logic z, input logic [5:0] op,
                     input logic [3:0] s, input logic ill = 0, input logic be = 0);
    memReady = mr;
    zero = z;
    opcode = op;
    sb.push_back('{nm, exp_vec(s, mr, z, op, ill, be)});
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cyc(input string nm);
    resetN = 1'b0;
    memReady = 1'b1;
    sb.push_back('{nm, 21'd0});
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    rst_cyc("reset0");
    rst_cyc("reset1");
    resetN = 1'b1;
    cyc("add_fetch", 1, 0, RT, F);
    cyc("add_decode", 1, 0, RT, D);
    cyc("add_exec", 0, 0, RT, EX);
    cyc("add_wb", 0, 0, RT, AWB);
    cyc("lw_fetch_wait", 0, 0, LW, F);
    cyc("lw_fetch", 1, 0, LW, F);
    cyc("lw_decode", 0, 0, LW, D);
    cyc("lw_adr", 1, 0, LW, MA);
    for (int i = 0; i < 3; i++) cyc("lw_read_wait", 0, 0, LW, MR);
    cyc("lw_read", 1, 0, LW, MR);
    cyc("lw_wb", 0, 0, LW, MWB);
    cyc("beq_fetch", 1, 1, BEQ, F);
    cyc("beq_decode", 0, 1, BEQ, D);
    cyc("beq_taken", 0, 1, BEQ, BR);
    cyc("bne_fetch", 1, 1, BNE, F);
    cyc("bne_decode", 0, 1, BNE, D);
    cyc("bne_z1", 0, 1, BNE, BR);
    cyc("bne_fetch", 1, 0, BNE, F);
    cyc("bne_decode", 0, 0, BNE, D);
    cyc("bne_z0", 0, 0, BNE, BR);
    cyc("beq_fetch", 1, 0, BEQ, F);
    cyc("beq_decode", 0, 0, BEQ, D);
    cyc("beq_not", 0, 0, BEQ, BR);
    cyc("j_fetch", 1, 0, JMP, F);
    cyc("j_decode", 0, 0, JMP, D);
    cyc("j_jump", 0, 0, JMP, JP);
    cyc("addi_fetch", 1, 0, ADDI, F);
    cyc("addi_decode", 0, 0, ADDI, D);
    cyc("addi_ex", 1, 0, ADDI, AIX);
    cyc("addi_wb", 0, 0, ADDI, AIW);
    cyc("sw_fetch", 1, 0, SW, F);
    cyc("sw_decode", 0, 0, SW, D);
    cyc("sw_adr", 0, 0, SW, MA);
    cyc("sw_write", 1, 0, SW, MW);
    cyc("sw4_fetch", 1, 0, SW, F);
    cyc("sw4_decode", 0, 0, SW, D);
    cyc("sw4_adr", 0, 0, SW, MA);
    for (int i = 0; i < 3; i++) cyc("sw4_wait", 0, 0, SW, MW);
    cyc("sw4_ready_at_limit", 1, 0, SW, MW);
    cyc("sw4_back_fetch", 1, 0, RT, F);
    cyc("sw4_decode2", 0, 0, RT, D, 0, 0);
    cyc("sw4_exec2", 0, 0, RT, EX);
    cyc("sw4_wb2", 0, 0, RT, AWB);
    cyc("swto_fetch", 1, 0, SW, F);
    cyc("swto_decode", 0, 0, SW, D);
    cyc("swto_adr", 0, 0, SW, MA);
    for (int i = 0; i < 4; i++) cyc("swto_wait", 0, 0, SW, MW);
    for (int i = 0; i < 3; i++) cyc("swto_trap", 1, 1, SW, TR, 0, 1);
    rst_cyc("swto_reset");
    resetN = 1'b1;
    cyc("fto_wait", 0, 0, RT, F);
    for (int i = 0; i < 3; i++) cyc("fto_wait", 0, 0, RT, F);
    cyc("fto_trap", 1, 0, RT, TR, 0, 1);
    rst_cyc("fto_reset");
    resetN = 1'b1;
    cyc("ill_fetch", 1, 0, BAD, F);
    cyc("ill_decode", 1, 0, BAD, D);
    for (int i = 0; i < 22; i++) cyc("ill_trap", i[0], i[1], BAD, TR, 1, 0);
    rst_cyc("ill_reset");
    resetN = 1'b1;
    cyc("ill_cleared", 0, 0, SW, F);
    cyc("ar_fetch", 1, 0, SW, F);
    cyc("ar_decode", 0, 0, SW, D);
    cyc("ar_adr", 0, 0, SW, MA);
    cyc("ar_write", 0, 0, SW, MW);
    #2 resetN = 1'b0;
    #1;
    check("ar_async_memwrite", {3'b0, memWrite}, 4'd0);
    check("ar_async_memreq", {3'b0, memReq}, 4'd0);
    check("ar_async_state", state, F);
    sb.push_back('{"ar_hold", 21'd0});
    @(posedge clk);
    #1;
    rst_cyc("ar_hold2");
    resetN = 1'b1;
    cyc("ar_fetch_after", 1, 0, RT, F);
    cyc("ar_decode_after", 0, 0, RT, D);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port.
- Drives the datapath muxes and write enables, and produces the 2-bit aluOp consumed by the existing ALU control decoder.
- Handshakes with a variable-latency memory and traps on illegal opcodes or memory timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles to wait for memReady in a memory state before trapping. 0 disables the watchdog.
- STATE_W, 4: width of the state encoding exported on the state port.

Ports:
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- memReady  in  1  memory has completed the current access this cycle.
- memReq  out  1  memory access request.
- memWrite  out  1  store enable.
- iOrD  out  1  address mux: 0=PC, 1=ALUOut.
- irWrite  out  1  instruction register load.
- regWrite  out  1  register file write.
- regDst  out  1  destination register: 0=rt, 1=rd.
- memToReg  out  1  writeback source: 0=ALUOut, 1=MDR.
- aluSrcA  out  1  ALU A operand: 0=PC, 1=A.
- aluSrcB  out  2  ALU B operand: 00=B, 01=4, 10=SignImm, 11=SignImm<<2.
- aluOp  out  2  00=add, 01=sub, 10=funct-decoded.
- pcSrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target.
- pcEn  out  1  PC load, already combined with branch condition.
- illegalOp  out  1  sticky; decode saw an unsupported opcode.
- busErr  out  1  sticky; memory watchdog expired.
- state  out  STATE_W  current state, for debug and verification.

Behaviour:
- Reset:
  - resetN=0 forces state=FETCH, clears the watchdog counter, opLatched, illegalOp and busErr.
  - While resetN=0, memReq, memWrite, irWrite, regWrite and pcEn are forced to 0.
  - All other outputs are 0 during reset.
  - Assertion of resetN mid-instruction aborts it immediately, with no partial writes after the assertion.
- Outputs:
  - All outputs are decoded from state. The exceptions are irWrite/pcEn in FETCH and pcEn in BRANCH, described below.
  - Any output not listed for a state is 0. No X values are ever driven.
- States (encoding 0..12):
  - FETCH:
    - memReq=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
    - irWrite=pcEn=memReady.
    - Go to DECODE on memReady; otherwise stay.
  - DECODE:
    - aluSrcA=0, aluSrcB=11, aluOp=00. Latch opcode into opLatched.
    - Next state by opcode:
      - lw (100011) and sw (101011) go to MEMADR.
      - R-type (000000) goes to EXECUTE.
      - beq (000100) and bne (000101) go to BRANCH.
      - addi (001000) goes to ADDIEX.
      - j (000010) goes to JUMP.
      - Any other opcode goes to TRAP and sets illegalOp.
  - MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Go to MEMREAD if opLatched=lw, else MEMWRITE.
  - MEMREAD: memReq=1, iOrD=1. Go to MEMWB on memReady.
  - MEMWB: regWrite=1, regDst=0, memToReg=1. Go to FETCH.
  - MEMWRITE: memReq=1, memWrite=1, iOrD=1. Go to FETCH on memReady.
  - EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. Go to ALUWB.
  - ALUWB: regWrite=1, regDst=1, memToReg=0. Go to FETCH.
  - BRANCH:
    - aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01.
    - pcEn = zero for beq, ~zero for bne (selected by opLatched).
    - Go to FETCH.
  - ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00. Go to ADDIWB.
  - ADDIWB: regWrite=1, regDst=0, memToReg=0. Go to FETCH.
  - JUMP: pcSrc=10, pcEn=1. Go to FETCH.
  - TRAP: all enables 0; the cause flag stays high. Held until reset.
- Latency with memReady=1 in the first cycle of each memory state:
  - lw: 5 cycles.
  - R-type, sw, addi: 4 cycles.
  - beq, bne, j: 3 cycles.
  - Each cycle of memReady=0 adds one cycle.
- Watchdog:
  - The counter clears on entry to FETCH, MEMREAD or MEMWRITE.
  - It increments on each cycle spent in such a state with memReady=0.
  - When the count reaches TIMEOUT_CYCLES, go to TRAP and set busErr. The access is never considered complete.
  - memReady=1 in the same cycle the count would reach the limit: the access completes and there is no trap.
- memReady outside FETCH, MEMREAD or MEMWRITE is ignored.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - state encodings (S_FETCH .. S_TRAP);
  - aluOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - aluSrcB and pcSrc codes.
- One sub-module, mem_wait_timer:
  - inputs: clear, waiting, memReady;
  - output: expired;
  - parameter: TIMEOUT_CYCLES.
- The FSM core stays in multicycle_control.

Test Plan:
- add, opcode=000000, memReady=1 always: state sequence 0,1,6,7,0. irWrite=pcEn=1 in cycle 1 only. aluOp=10 in EXECUTE. regWrite=1, regDst=1 in ALUWB.
- lw with memReady low for 3 cycles in MEMREAD: sequence FETCH, DECODE, MEMADR, MEMREAD×4, MEMWB. iOrD=1 and memReq=1 throughout MEMREAD. memToReg=1 and regWrite=1 in MEMWB.
- beq with zero=1: pcEn=1, pcSrc=01, aluOp=01 in BRANCH. bne with zero=1: pcEn=0. bne with zero=0: pcEn=1. Each takes 3 cycles total.
- opcode=111111: DECODE goes to TRAP; illegalOp=1; pcEn, regWrite and memWrite stay 0 for 20+ cycles; resetN pulse returns state to FETCH with illegalOp=0.
- TIMEOUT_CYCLES=4, sw with memReady held 0 in MEMWRITE: TRAP after 4 waiting cycles with busErr=1. Repeat with memReady=1 on the 4th cycle: returns to FETCH, busErr=0.
- resetN driven low asynchronously mid-MEMWRITE: memWrite and memReq drop to 0 without waiting for a clock edge. After release, state=FETCH and memReq=1 on the first cycle.
